// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot/auto-reload modes, pause, abort and a done/ack handshake.
// All outputs come straight from flops; next-state logic lives in one always_comb.
module countdown_timer #(
  parameter int WIDTH        = 6,
  parameter int DEFAULT_LOAD = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DEFAULT_VAL = WIDTH'(DEFAULT_LOAD);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             expired_q, expired_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] start_val;

  assign start_val = load_en ? load_val : DEFAULT_VAL;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    mode_d    = mode_q;
    busy_d    = busy_q;
    expired_d = 1'b0;
    done_d    = done_q;

    if (abort) begin
      state_d = IDLE;
      count_d = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // A start in DONE doubles as an implicit ack.
          if (start) begin
            reload_d = start_val;
            count_d  = start_val;
            mode_d   = auto_reload;
            state_d  = RUN;
            busy_d   = 1'b1;
            done_d   = 1'b0;
          end else if (state_q == DONE && ack) begin
            state_d = IDLE;
            done_d  = 1'b0;
          end
        end
        RUN: begin
          if (!pause) begin
            if (count_q != '0) begin
              count_d = count_q - 1'b1;
            end else begin
              expired_d = 1'b1;
              if (mode_q) begin
                count_d = reload_q;
              end else begin
                state_d = DONE;
                count_d = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign count   = count_q;
  assign busy    = busy_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; outputs sampled 1ns after each rising edge.
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       load_en;
  logic [5:0] load_val;
  logic       auto_reload;
  logic       pause;
  logic       abort;
  logic       ack;
  logic [5:0] count;
  logic       busy;
  logic       expired;
  logic       done;

  int total_checks = 0;
  int bad_checks   = 0;

  countdown_timer #(.WIDTH(6), .DEFAULT_LOAD(63)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load_en     (load_en),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .pause       (pause),
    .abort       (abort),
    .ack         (ack),
    .count       (count),
    .busy        (busy),
    .expired     (expired),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input int exp_count, input int exp_busy,
                          input int exp_expired, input int exp_done);
    checkOutput({tag, ".count"},   32'(count),   32'(exp_count));
    checkOutput({tag, ".busy"},    32'(busy),    32'(exp_busy));
    checkOutput({tag, ".expired"}, 32'(expired), 32'(exp_expired));
    checkOutput({tag, ".done"},    32'(done),    32'(exp_done));
  endtask

  task automatic applyStimulus(input logic s, input logic le, input logic [5:0] lv,
                               input logic ar);
    start       = s;
    load_en     = le;
    load_val    = lv;
    auto_reload = ar;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    pause = 1'b0;
    abort = 1'b0;
    ack   = 1'b0;
    #12;
    checkAll("reset", 0, 0, 0, 0);
    reset = 1'b0;

    // 1: default load, one-shot, expiry 64 edges after start
    step();
    applyStimulus(1'b1, 1'b0, 6'd17, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkAll("t1_start", 63, 1, 0, 0);
    for (int i = 1; i <= 63; i++) begin
      step();
      checkOutput("t1_count", 32'(count), 32'(63 - i));
      checkOutput("t1_noexp", 32'(expired), 32'd0);
    end
    step();
    checkAll("t1_expire", 0, 0, 1, 1);
    step();
    checkAll("t1_done_hold", 0, 0, 0, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    checkAll("t1_ack", 0, 0, 0, 0);
    step();
    checkAll("t1_idle", 0, 0, 0, 0);

    // 2: load 5, auto-reload, period 6
    applyStimulus(1'b1, 1'b1, 6'd5, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkAll("t2_start", 5, 1, 0, 0);
    for (int k = 1; k <= 18; k++) begin
      step();
      checkAll("t2_run", (k % 6 == 0) ? 5 : 5 - (k % 6), 1, (k % 6 == 0) ? 1 : 0, 0);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkAll("t2_abort", 0, 0, 0, 0);

    // 3: load 10, pause for 3 cycles at count 7 (start during pause is ignored)
    applyStimulus(1'b1, 1'b1, 6'd10, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkAll("t3_start", 10, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      checkOutput("t3_pre", 32'(count), 32'(10 - i));
    end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) applyStimulus(1'b1, 1'b1, 6'd40, 1'b1);
      step();
      applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
      checkAll("t3_paused", 7, 1, 0, 0);
    end
    pause = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      checkAll("t3_post", 7 - i, 1, 0, 0);
    end
    step();
    checkAll("t3_expire", 0, 0, 1, 1);

    // 5b: start from DONE acts as implicit ack; 4: abort at count 3
    applyStimulus(1'b1, 1'b1, 6'd4, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkAll("t5_restart", 4, 1, 0, 0);
    step();
    checkAll("t4_at3", 3, 1, 0, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkAll("t4_abort", 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      checkAll("t4_quiet", 0, 0, 0, 0);
    end

    // ack in IDLE and pause in IDLE are ignored
    ack   = 1'b1;
    pause = 1'b1;
    step();
    ack   = 1'b0;
    pause = 1'b0;
    checkAll("idle_ignore", 0, 0, 0, 0);

    // 6: load 0 expires on first RUN edge
    applyStimulus(1'b1, 1'b1, 6'd0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkAll("t6_start", 0, 1, 0, 0);
    step();
    checkAll("t6_expire", 0, 0, 1, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    checkAll("t6_ack", 0, 0, 0, 0);

    // 6b: async reset mid-run clears outputs before the next edge
    applyStimulus(1'b1, 1'b1, 6'd20, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    step();
    step();
    checkAll("t6_run", 18, 1, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    checkAll("t6_async_reset", 0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();
    checkAll("t6_after_reset", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
